divide_nr_param: RTL and testbench
==================================

Name: divide_nr_param

Overview:
- Parametrised sequential non-restoring integer divider; next generation of the fixed 32-bit `divide` block.
- Adds width parameter, per-operation signed/unsigned mode, async reset, busy/ready handshake, divide-by-zero and signed-overflow flags.
- Used by neural-network datapath normalisation stages; one division in flight at a time.

Parameters:
- WIDTH, 32, operand/result width in bits (legal range 4..64).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when ready=1.
- sign  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- dividend  in  WIDTH  numerator; sampled with start.
- divider  in  WIDTH  denominator; sampled with start.
- quotient  out  WIDTH  result, held until next accepted start.
- remainder  out  WIDTH  result, held until next accepted start.
- ready  out  1  idle/result-valid; 1 = may accept start.
- busy  out  1  equals ~ready.
- div_by_zero  out  1  last operation had divider==0.
- overflow  out  1  last operation was signed MIN / -1.

Behaviour:
- Reset (async, any state): state=IDLE, ready=1, busy=0, quotient=0, remainder=0, div_by_zero=0, overflow=0, counter=0. Reset mid-operation aborts it; no result produced.
- States: IDLE -> LOAD -> CALC -> FIX -> IDLE.
- IDLE: on start=1 at edge N, latch operands and sign; ready falls after edge N; clear both flags; go LOAD.
- start while ready=0 is ignored (no queueing, operands not relatched).
- LOAD (1 cycle): compute magnitudes. Signed mode: |x| as WIDTH-bit unsigned (MIN maps to 2^(WIDTH-1)). Record q_neg = sign_dividend XOR sign_divider, r_neg = sign_dividend. Unsigned mode: magnitudes = raw operands, q_neg = r_neg = 0.
- LOAD with divider==0: skip CALC, go FIX, set div_by_zero.
- CALC: exactly WIDTH cycles, one quotient bit per cycle.
  - Partial remainder P is WIDTH+1 bits signed.
  - If P>=0: P = 2P + next_bit - D; else P = 2P + next_bit + D.
  - Quotient bit = ~P_new[msb].
- FIX (1 cycle):
  - Remainder restore: if P<0, P += D.
  - Apply signs: quotient negated if q_neg; remainder negated if r_neg.
  - Write outputs, return to IDLE with ready=1.
- Latency: start accepted at edge N -> ready=1 and results valid after edge N+WIDTH+2. Divide-by-zero: after edge N+2.
- Semantics: truncation toward zero; remainder takes dividend's sign; dividend == quotient*divider + remainder (mod 2^WIDTH).
- Divide by zero: quotient = all ones, remainder = dividend (raw), div_by_zero=1, overflow=0.
- Signed MIN / -1: quotient = MIN (wraps), remainder=0, overflow=1, full latency.
- start asserted in the same cycle ready rises: accepted on the next edge (back-to-back, zero idle cycles).
- Flags and results stable while ready=1 until the next accepted start.

Test Plan:
- WIDTH=32, sign=1: 10/2 -> q=5, r=0; 10/3 -> q=3, r=1; ready rises exactly 34 cycles after accepting edge.
- WIDTH=32, sign=1: -10/2 -> q=-5 (0xFFFFFFFB), r=0; 10/-4 -> q=-2, r=2; -7/2 -> q=-3, r=-1.
- WIDTH=8, sign=0: 0xFF/0x10 -> q=0x0F, r=0x0F. Same operands with sign=1 (-1/16) -> q=0, r=0xFF.
- WIDTH=8, edge cases:
  - 0x80/0xFF with sign=1 -> q=0x80, r=0, overflow=1.
  - 0x55/0 -> q=0xFF, r=0x55, div_by_zero=1, ready after 2 cycles.
  - Next valid start clears both flags.
- Handshake:
  - start pulsed mid-CALC with new operands -> ignored, first result unchanged.
  - start held high continuously -> back-to-back results with no idle cycle.
- rst asserted asynchronously mid-CALC -> ready=1 and all outputs 0 immediately, before the next clock edge. A following 100/7 (sign=0) -> q=14, r=2.

Source files
------------

// File: rtl/divide_nr_param.sv
// Sequential non-restoring integer divider, one quotient bit per clock.
// Signed or unsigned per operation, with divide-by-zero and MIN/-1 overflow flags.
module divide_nr_param #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sign,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divider,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             ready,
   output logic             busy,
   output logic             div_by_zero,
   output logic             overflow
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_FIX} state_t;

   state_t           r_state;
   logic             r_sign;
   logic [WIDTH-1:0] r_dvd_raw;
   logic [WIDTH-1:0] r_dvs_raw;
   logic [WIDTH-1:0] r_n;
   logic [WIDTH:0]   r_d;
   logic [WIDTH:0]   r_p;
   logic [WIDTH-1:0] r_q;
   logic [CNT_W-1:0] r_cnt;
   logic             r_q_neg;
   logic             r_r_neg;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
   logic             r_ready;
   logic             r_dbz;
   logic             r_ovf;

   logic             w_dvd_neg;
   logic             w_dvs_neg;
   logic [WIDTH-1:0] w_dvd_mag;
   logic [WIDTH-1:0] w_dvs_mag;
   logic [WIDTH-1:0] w_min;
   logic             w_ovf;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_p_next;
   logic [WIDTH-1:0] w_r_mag;
   logic [WIDTH-1:0] w_q_fix;
   logic [WIDTH-1:0] w_r_fix;

   assign w_dvd_neg = r_sign & r_dvd_raw[WIDTH-1];
   assign w_dvs_neg = r_sign & r_dvs_raw[WIDTH-1];
   // Magnitudes are unsigned, so the most negative value maps to 2^(WIDTH-1).
   assign w_dvd_mag = w_dvd_neg ? -r_dvd_raw : r_dvd_raw;
   assign w_dvs_mag = w_dvs_neg ? -r_dvs_raw : r_dvs_raw;
   assign w_min     = {1'b1, {(WIDTH-1){1'b0}}};
   assign w_ovf     = r_sign && (r_dvd_raw == w_min) && (r_dvs_raw == '1);

   // Shift in the next dividend bit, then subtract or add D depending on the sign of P.
   assign w_shift  = {r_p[WIDTH-1:0], r_n[WIDTH-1]};
   assign w_p_next = r_p[WIDTH] ? (w_shift + r_d) : (w_shift - r_d);

   assign w_r_mag = r_p[WIDTH] ? (r_p[WIDTH-1:0] + r_d[WIDTH-1:0]) : r_p[WIDTH-1:0];
   assign w_q_fix = r_q_neg ? -r_q : r_q;
   assign w_r_fix = r_r_neg ? -w_r_mag : w_r_mag;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_sign      <= 1'b0;
         r_dvd_raw   <= '0;
         r_dvs_raw   <= '0;
         r_n         <= '0;
         r_d         <= '0;
         r_p         <= '0;
         r_q         <= '0;
         r_cnt       <= '0;
         r_q_neg     <= 1'b0;
         r_r_neg     <= 1'b0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_ready     <= 1'b1;
         r_dbz       <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_sign    <= sign;
                  r_dvd_raw <= dividend;
                  r_dvs_raw <= divider;
                  r_ready   <= 1'b0;
                  r_dbz     <= 1'b0;
                  r_ovf     <= 1'b0;
                  r_state   <= S_LOAD;
               end
            end
            S_LOAD: begin
               r_n     <= w_dvd_mag;
               r_d     <= {1'b0, w_dvs_mag};
               r_p     <= '0;
               r_q     <= '0;
               r_q_neg <= w_dvd_neg ^ w_dvs_neg;
               r_r_neg <= w_dvd_neg;
               r_cnt   <= CNT_W'(WIDTH);
               if (r_dvs_raw == '0) begin
                  r_dbz   <= 1'b1;
                  r_state <= S_FIX;
               end else begin
                  r_ovf   <= w_ovf;
                  r_state <= S_CALC;
               end
            end
            S_CALC: begin
               r_p   <= w_p_next;
               r_q   <= {r_q[WIDTH-2:0], ~w_p_next[WIDTH]};
               r_n   <= {r_n[WIDTH-2:0], 1'b0};
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  r_state <= S_FIX;
               end
            end
            S_FIX: begin
               if (r_dbz) begin
                  r_quotient  <= '1;
                  r_remainder <= r_dvd_raw;
               end else begin
                  r_quotient  <= w_q_fix;
                  r_remainder <= w_r_fix;
               end
               r_cnt   <= '0;
               r_ready <= 1'b1;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign quotient    = r_quotient;
   assign remainder   = r_remainder;
   assign ready       = r_ready;
   assign busy        = ~r_ready;
   assign div_by_zero = r_dbz;
   assign overflow    = r_ovf;

endmodule

// File: tb/tb_divide_nr_param.sv
// Scoreboard bench for divide_nr_param: a 32-bit and an 8-bit instance driven by
// directed and random operations, checked against an arithmetic reference model.
module tb_divide_nr_param;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        start32 = 1'b0, sign32 = 1'b0;
   logic [31:0] dividend32 = '0, divider32 = '0;
   logic [31:0] quotient32, remainder32;
   logic        ready32, busy32, dbz32, ovf32;

   logic        start8 = 1'b0, sign8 = 1'b0;
   logic [7:0]  dividend8 = '0, divider8 = '0;
   logic [7:0]  quotient8, remainder8;
   logic        ready8, busy8, dbz8, ovf8;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   typedef struct {
      logic        s;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] q;
      logic [63:0] r;
      logic        dbz;
      logic        ovf;
      int          acc;
      int          lat;
   } exp_t;

   exp_t sb32[$];
   exp_t sb8[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   divide_nr_param #(.WIDTH(32)) u_dut32 (
      .clk(clk), .rst(rst), .start(start32), .sign(sign32),
      .dividend(dividend32), .divider(divider32),
      .quotient(quotient32), .remainder(remainder32),
      .ready(ready32), .busy(busy32), .div_by_zero(dbz32), .overflow(ovf32)
   );

   divide_nr_param #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .sign(sign8),
      .dividend(dividend8), .divider(divider8),
      .quotient(quotient8), .remainder(remainder8),
      .ready(ready8), .busy(busy8), .div_by_zero(dbz8), .overflow(ovf8)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain integer division with truncation toward zero.
   function automatic exp_t model(input int w, input logic s, input logic [63:0] a_in,
                                  input logic [63:0] b_in);
      exp_t        e;
      logic [63:0] mask;
      longint      sa, sb, sq, sr;
      mask  = (64'd1 << w) - 64'd1;
      e.s   = s;
      e.a   = a_in & mask;
      e.b   = b_in & mask;
      e.dbz = 1'b0;
      e.ovf = 1'b0;
      e.acc = 0;
      e.lat = w + 2;
      if (e.b == 64'd0) begin
         e.q   = mask;
         e.r   = e.a;
         e.dbz = 1'b1;
         e.lat = 2;
      end else if (s) begin
         sa = longint'(e.a);
         sb = longint'(e.b);
         if (e.a[w-1]) sa = sa - (longint'(1) << w);
         if (e.b[w-1]) sb = sb - (longint'(1) << w);
         sq = sa / sb;
         sr = sa % sb;
         e.q   = 64'(sq) & mask;
         e.r   = 64'(sr) & mask;
         e.ovf = (sa == -(longint'(1) << (w - 1))) && (sb == -1);
      end else begin
         e.q = e.a / e.b;
         e.r = e.a % e.b;
      end
      return e;
   endfunction

   function automatic logic rdy(input int inst);
      return (inst == 0) ? ready32 : ready8;
   endfunction

   task automatic drive(input int inst, input logic st, input logic s,
                        input logic [63:0] a, input logic [63:0] b);
      if (inst == 0) begin
         start32 = st; sign32 = s; dividend32 = a[31:0]; divider32 = b[31:0];
      end else begin
         start8 = st; sign8 = s; dividend8 = a[7:0]; divider8 = b[7:0];
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic do_op(input int inst, input logic s, input logic [63:0] a,
                        input logic [63:0] b, input bit hold);
      int   n;
      exp_t e;
      n = 0;
      while (!rdy(inst) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!rdy(inst)) begin
         tests++;
         fails++;
         $display("FAIL ready_timeout inst=%0d: got ready=0 expected ready=1", inst);
      end
      drive(inst, 1'b1, s, a, b);
      e     = model((inst == 0) ? 32 : 8, s, a, b);
      e.acc = cyc + 1;
      if (inst == 0) sb32.push_back(e);
      else           sb8.push_back(e);
      @(negedge clk);
      chk($sformatf("accept_inst%0d", inst), {63'd0, rdy(inst)}, 64'd0);
      if (!hold) drive(inst, 1'b0, s, a, b);
   endtask

   task automatic wait_idle(input int inst);
      int n;
      n = 0;
      while (!rdy(inst) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("idle_inst%0d", inst), {63'd0, rdy(inst)}, 64'd1);
   endtask

   task automatic check_result(input string tag, input exp_t e, input logic [63:0] q,
                               input logic [63:0] r, input logic dbz, input logic ovf,
                               input logic bsy, input int lat);
      $display("[TB] %s sign=%0d 0x%0h / 0x%0h -> q=0x%0h r=0x%0h dbz=%0d ovf=%0d lat=%0d",
               tag, e.s, e.a, e.b, q, r, dbz, ovf, lat);
      chk({tag, "_quotient"},  q, e.q);
      chk({tag, "_remainder"}, r, e.r);
      chk({tag, "_dbz"},       {63'd0, dbz}, {63'd0, e.dbz});
      chk({tag, "_ovf"},       {63'd0, ovf}, {63'd0, e.ovf});
      chk({tag, "_busy"},      {63'd0, bsy}, 64'd0);
      chk({tag, "_latency"},   64'(lat), 64'(e.lat));
   endtask

   initial begin : mon32
      exp_t        e;
      logic        prev;
      logic [63:0] hq, hr;
      logic        hd, ho;
      prev = 1'b1; hq = '0; hr = '0; hd = 1'b0; ho = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            hq = '0; hr = '0; hd = 1'b0; ho = 1'b0;
         end else if (ready32 && !prev) begin
            if (sb32.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL w32_unexpected: got result q=0x%0h expected none", quotient32);
            end else begin
               e = sb32.pop_front();
               check_result("w32", e, quotient32, remainder32, dbz32, ovf32, busy32, cyc - e.acc);
               hq = e.q; hr = e.r; hd = e.dbz; ho = e.ovf;
            end
         end else if (ready32) begin
            chk("w32_hold_q", quotient32, hq);
            chk("w32_hold_r", remainder32, hr);
            chk("w32_hold_flags", {62'd0, dbz32, ovf32}, {62'd0, hd, ho});
         end
         prev = ready32 | rst;
      end
   end

   initial begin : mon8
      exp_t        e;
      logic        prev;
      logic [63:0] hq, hr;
      logic        hd, ho;
      prev = 1'b1; hq = '0; hr = '0; hd = 1'b0; ho = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            hq = '0; hr = '0; hd = 1'b0; ho = 1'b0;
         end else if (ready8 && !prev) begin
            if (sb8.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL w8_unexpected: got result q=0x%0h expected none", quotient8);
            end else begin
               e = sb8.pop_front();
               check_result("w8", e, quotient8, remainder8, dbz8, ovf8, busy8, cyc - e.acc);
               hq = e.q; hr = e.r; hd = e.dbz; ho = e.ovf;
            end
         end else if (ready8) begin
            chk("w8_hold_q", quotient8, hq);
            chk("w8_hold_r", remainder8, hr);
            chk("w8_hold_flags", {62'd0, dbz8, ovf8}, {62'd0, hd, ho});
         end
         prev = ready8 | rst;
      end
   end

   function automatic logic [63:0] pick(input int w, input bit nz);
      logic [63:0] mask;
      logic [63:0] v;
      mask = (64'd1 << w) - 64'd1;
      case ($urandom_range(0, 6))
         0:       v = nz ? 64'd1 : 64'd0;
         1:       v = 64'd1 << (w - 1);
         2:       v = mask;
         3:       v = 64'($urandom_range(1, 20));
         default: v = {32'($urandom), 32'($urandom)};
      endcase
      return v & mask;
   endfunction

   initial begin : stim
      int n;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      chk("rst_ready32", {63'd0, ready32}, 64'd1);
      chk("rst_busy32",  {63'd0, busy32},  64'd0);
      chk("rst_q32",     64'(quotient32),  64'd0);
      chk("rst_r32",     64'(remainder32), 64'd0);
      chk("rst_flags8",  {62'd0, dbz8, ovf8}, 64'd0);
      chk("rst_ready8",  {63'd0, ready8}, 64'd1);

      do_op(0, 1'b1, 64'd10, 64'd2, 1'b0);
      do_op(0, 1'b1, 64'd10, 64'd3, 1'b0);
      do_op(0, 1'b1, -64'd10, 64'd2, 1'b0);
      do_op(0, 1'b1, 64'd10, -64'd4, 1'b0);
      do_op(0, 1'b1, -64'd7, 64'd2, 1'b0);

      do_op(1, 1'b0, 64'hFF, 64'h10, 1'b0);
      do_op(1, 1'b1, 64'hFF, 64'h10, 1'b0);
      do_op(1, 1'b1, 64'h80, 64'hFF, 1'b0);
      do_op(1, 1'b0, 64'h55, 64'h00, 1'b0);
      do_op(1, 1'b0, 64'h55, 64'h03, 1'b0);

      // A start pulse while busy must be ignored entirely.
      do_op(0, 1'b1, 64'd10, 64'd3, 1'b0);
      repeat (5) @(negedge clk);
      drive(0, 1'b1, 1'b1, 64'd1000, 64'd7);
      @(negedge clk);
      drive(0, 1'b0, 1'b0, 64'd0, 64'd0);

      // Start held high: each result is followed immediately by the next accept.
      do_op(1, 1'b1, 64'h80, 64'hFF, 1'b1);
      do_op(1, 1'b0, 64'h64, 64'h00, 1'b1);
      do_op(1, 1'b1, 64'h9C, 64'h07, 1'b1);
      do_op(1, 1'b0, 64'hC8, 64'h0D, 1'b0);

      // Asynchronous reset in the middle of a calculation.
      wait_idle(0);
      wait_idle(1);
      do_op(0, 1'b0, 64'd12345, 64'd17, 1'b0);
      repeat (10) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("async_rst_ready", {63'd0, ready32}, 64'd1);
      chk("async_rst_busy",  {63'd0, busy32},  64'd0);
      chk("async_rst_q",     64'(quotient32),  64'd0);
      chk("async_rst_r",     64'(remainder32), 64'd0);
      chk("async_rst_flags", {62'd0, dbz32, ovf32}, 64'd0);
      sb32.delete();
      @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      do_op(0, 1'b0, 64'd100, 64'd7, 1'b0);

      for (int i = 0; i < 24; i++) begin
         do_op(i % 2, 1'($urandom_range(0, 1)), pick((i % 2) ? 8 : 32, 1'b0),
               pick((i % 2) ? 8 : 32, (i % 5) != 0), 1'b0);
      end

      n = 0;
      while ((sb32.size() != 0 || sb8.size() != 0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk("drain32", 64'(sb32.size()), 64'd0);
      chk("drain8",  64'(sb8.size()),  64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
